// File: rtl/wb_multi_src.sv
// rtl/wb_multi_src.sv - multi-source writeback stage with per-source FIFOs and round-robin drain
//
// Collects results from NUM_SRC execution units into small private FIFOs and
// drains at most one entry per cycle onto the registered register-file write port.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   src_valid  per-source result valid
//   src_ready  per-source FIFO not full (state only)
//   src_rd     per-source destination register, source i at [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   src_data   per-source result, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   flush      discard every buffered result and the beats presented this cycle
//   wb_addr    register-file write address (registered)
//   wb_data    register-file write data (registered)
//   wb_en      register-file write enable (registered)
//   idle       all source FIFOs empty
module wb_multi_src #(
  parameter int NUM_SRC        = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SRC-1:0]                 src_valid,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  src_rd,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data,
  input  logic                               flush,
  output logic [REG_ADDR_WIDTH-1:0]          wb_addr,
  output logic [DATA_WIDTH-1:0]              wb_data,
  output logic                               wb_en,
  output logic                               idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(NUM_SRC);
  localparam int EW = REG_ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0]             mem_q    [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q [NUM_SRC];
  logic [PW-1:0]             rd_ptr_q [NUM_SRC];
  logic [CW-1:0]             count_q  [NUM_SRC];
  logic [SW-1:0]             rr_ptr_q;
  logic [SW-1:0]             rr_ptr_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;
  logic                      wb_en_q;

  logic [NUM_SRC-1:0]        push;
  logic [NUM_SRC-1:0]        pop;
  logic                      grant_found;
  logic [SW-1:0]             grant_idx;
  logic [EW-1:0]             head;
  int                        idx;

  // Ready and push qualification. Ready looks only at occupancy so a full FIFO
  // stays not-ready even in a cycle where it is being popped.
  always_comb begin
    src_ready = '0;
    push      = '0;
    idle      = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count_q[i] != CW'(FIFO_DEPTH));
      // Writes to x0 complete the handshake but are never stored.
      push[i]      = src_valid[i] & src_ready[i] &
                     (src_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0);
      if (count_q[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  // Round-robin search starting at rr_ptr_q; only entries present at cycle
  // start are eligible, so a same-cycle push is never bypassed.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!grant_found && (count_q[idx] != '0)) begin
        grant_found = 1'b1;
        grant_idx   = SW'(idx);
      end
    end

    pop = '0;
    if (grant_found) begin
      pop[grant_idx] = 1'b1;
    end

    head = mem_q[grant_idx][rd_ptr_q[grant_idx]];

    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      rr_ptr_d = (grant_idx == SW'(NUM_SRC - 1)) ? '0 : grant_idx + SW'(1);
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      wb_en_q  <= 1'b0;
      // A flush keeps the last address/data visible; only reset clears them.
      if (reset) begin
        wb_addr_q <= '0;
        wb_data_q <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        end
        if (push[i] && !pop[i]) begin
          count_q[i] <= count_q[i] + CW'(1);
        end else if (pop[i] && !push[i]) begin
          count_q[i] <= count_q[i] - CW'(1);
        end
      end
      rr_ptr_q <= rr_ptr_d;
      if (grant_found) begin
        wb_en_q   <= 1'b1;
        wb_addr_q <= head[EW-1 -: REG_ADDR_WIDTH];
        wb_data_q <= head[DATA_WIDTH-1:0];
      end else begin
        wb_en_q <= 1'b0;
      end
    end
  end

  // Storage array has no reset; validity is tracked entirely by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!reset && !flush && push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {src_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                                  src_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign wb_en   = wb_en_q;

endmodule

// File: tb/tb_wb_multi_src.sv
// tb/tb_wb_multi_src.sv - self-checking bench for wb_multi_src
module tb_wb_multi_src;

  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 2;
  localparam int EW = AW + DW;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*AW-1:0]  src_rd;
  logic [NS*DW-1:0]  src_data;
  logic              flush;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              wb_en;
  logic              idle;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] obs_q [$];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] src_q [NS][$];

  wb_multi_src #(
    .NUM_SRC(NS), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .flush(flush),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en), .idle(idle)
  );

  always #5 clk = ~clk;

  // Advance one edge and record any write the DUT produced.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_en) obs_q.push_back({wb_addr, wb_data});
  endtask

  task automatic clear_inputs();
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    src_valid[s]       = 1'b1;
    src_rd[s*AW +: AW] = rd;
    src_data[s*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b exp 0", wb_en); end
    checks++; if (wb_addr !== '0) begin errors++; $display("FAIL reset_wb_addr got %h exp 0", wb_addr); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", src_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
  endtask

  task automatic test_single();
    set_src(0, 5'd5, 32'hDEADBEEF);
    tick();
    clear_inputs();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL single_latency got wb_en %b exp 0", wb_en); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy got idle %b exp 0", idle); end
    tick();
    checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", wb_en); end
    checks++; if (wb_addr !== 5'd5) begin errors++; $display("FAIL single_addr got %h exp 05", wb_addr); end
    checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", wb_data); end
    tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL single_en_drop got %b exp 0", wb_en); end
    checks++; if (wb_addr !== 5'd5) begin errors++; $display("FAIL single_addr_hold got %h exp 05", wb_addr); end
    checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data_hold got %h exp deadbeef", wb_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", idle); end
    obs_q.delete();
  endtask

  task automatic test_x0();
    checks++; if (src_ready[1] !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", src_ready[1]); end
    set_src(1, 5'd0, 32'h0000_1234);
    tick();
    clear_inputs();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL x0_idle got %b exp 1", idle); end
    repeat (4) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL x0_writes got %0d exp 0", obs_q.size()); end
    checks++; if (wb_addr !== 5'd5) begin errors++; $display("FAIL x0_addr_hold got %h exp 05", wb_addr); end
    obs_q.delete();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int s = 0; s < NS; s++) begin
      set_src(s, AW'(s + 1), 32'h1000 + DW'(s));
      exp_q.push_back({AW'(s + 1), 32'h1000 + DW'(s)});
    end
    tick();
    for (int s = 0; s < NS; s++) begin
      set_src(s, AW'(s + 4), 32'h2000 + DW'(s));
      exp_q.push_back({AW'(s + 4), 32'h2000 + DW'(s)});
    end
    tick();
    clear_inputs();
    repeat (5) tick();
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL rr_count got %0d exp 6", obs_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rr_order[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_pressure();
    int seq [NS];
    int sent0;
    int n0;
    bit ready0_low;
    logic [EW-1:0] e;
    logic [7:0] s;
    do_reset();
    for (int i = 0; i < NS; i++) begin
      seq[i] = 0;
      src_q[i].delete();
    end
    sent0 = 0;
    ready0_low = 1'b0;
    for (int cyc = 0; cyc < 100 && sent0 < 6; cyc++) begin
      for (int i = 0; i < NS; i++) begin
        set_src(i, AW'((seq[i] % 31) + 1), {8'(i), 24'(seq[i])});
      end
      if (!src_ready[0]) ready0_low = 1'b1;
      for (int i = 0; i < NS; i++) begin
        if (src_ready[i]) begin
          src_q[i].push_back({AW'((seq[i] % 31) + 1), 8'(i), 24'(seq[i])});
          seq[i]++;
          if (i == 0) sent0++;
        end
      end
      tick();
    end
    clear_inputs();
    repeat (20) tick();
    checks++; if (sent0 != 6) begin errors++; $display("FAIL bp_sent got %0d exp 6", sent0); end
    checks++; if (!ready0_low) begin errors++; $display("FAIL bp_ready_drop got never-low exp low"); end
    n0 = 0;
    foreach (obs_q[k]) begin
      s = obs_q[k][DW-1 -: 8];
      checks++;
      if (s >= NS || src_q[s].size() == 0) begin
        errors++; $display("FAIL bp_unexpected got %h exp none", obs_q[k]);
      end else begin
        e = src_q[s].pop_front();
        if (s == 0) n0++;
        if (obs_q[k] !== e) begin
          errors++; $display("FAIL bp_order src%0d got %h exp %h", s, obs_q[k], e);
        end
      end
    end
    checks++; if (n0 != 6) begin errors++; $display("FAIL bp_src0_writes got %0d exp 6", n0); end
    for (int i = 0; i < NS; i++) begin
      checks++;
      if (src_q[i].size() != 0) begin
        errors++; $display("FAIL bp_lost src%0d got %0d missing exp 0", i, src_q[i].size());
      end
    end
    obs_q.delete();
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NS; s++) begin
        set_src(s, AW'(8 + 3 * r + s), 32'h3000 + DW'(16 * r + s));
      end
      tick();
    end
    clear_inputs();
    flush = 1'b1;
    set_src(2, 5'd7, 32'hF1F1F1F1);
    tick();
    clear_inputs();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_en got %b exp 0", wb_en); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle got %b exp 1", idle); end
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL flush_ready got %b exp 111", src_ready); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL flush_pre_writes got %0d exp 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++;
      if (obs_q[0] !== {5'd8, 32'h3000}) begin
        errors++; $display("FAIL flush_pre_entry got %h exp %h", obs_q[0], {5'd8, 32'h3000});
      end
    end
    obs_q.delete();
    repeat (5) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL flush_post_writes got %0d exp 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NS; s++) begin
        set_src(s, AW'(20 + 3 * r + s), 32'h4000 + DW'(16 * r + s));
      end
      tick();
    end
    clear_inputs();
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got idle %b exp 0", idle); end
    reset = 1'b1;
    tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_mid_en got %b exp 0", wb_en); end
    checks++; if (wb_addr !== '0) begin errors++; $display("FAIL rst_mid_addr got %h exp 0", wb_addr); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", wb_data); end
    checks++; if (src_ready !== 3'b111) begin errors++; $display("FAIL rst_mid_ready got %b exp 111", src_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got %b exp 1", idle); end
    reset = 1'b0;
    obs_q.delete();
    repeat (4) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rst_mid_writes got %0d exp 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_x0();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
